// File: rtl/lw_hmac_multikey.sv
// lw_hmac_multikey: HMAC sequencer driving a streaming SHA core, NUM_KEYS key slots.
// Define HMAC_KEY_ZEROIZE_EN to wipe a slot after each completed or aborted use.
module lw_hmac_multikey #(
  parameter int WORD_W       = 32,
  parameter int DIGEST_WORDS = 8,
  parameter int NUM_KEYS     = 4,
  localparam int SLOT_W      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int HASH_W      = DIGEST_WORDS * WORD_W
) (
  input  logic              clk_i,
  input  logic              aresetn_i,
  input  logic              key_wr_i,
  input  logic [SLOT_W-1:0] key_slot_i,
  input  logic [3:0]        key_idx_i,
  input  logic [WORD_W-1:0] key_word_i,
  input  logic              start_i,
  input  logic [SLOT_W-1:0] slot_sel_i,
  input  logic              abort_i,
  input  logic              msg_valid_i,
  input  logic [WORD_W-1:0] msg_data_i,
  input  logic              msg_last_i,
  output logic              msg_ready_o,
  output logic              sha_start_o,
  output logic              sha_valid_o,
  output logic [WORD_W-1:0] sha_data_o,
  output logic              sha_last_o,
  input  logic              sha_ready_i,
  input  logic              sha_done_i,
  input  logic [HASH_W-1:0] sha_hash_i,
  output logic [HASH_W-1:0] mac_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [WORD_W-1:0] IPAD = {(WORD_W/8){8'h36}};
  localparam logic [WORD_W-1:0] OPAD = {(WORD_W/8){8'h5c}};
  localparam logic [SLOT_W:0]   NK   = (SLOT_W+1)'(NUM_KEYS);
  localparam logic [3:0]        LAST_DIG = 4'(DIGEST_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    IN_KEY,
    IN_MSG,
    IN_WAIT,
    OUT_KEY,
    OUT_DIG,
    OUT_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                first_q, first_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [HASH_W-1:0]   inner_q, inner_d;
  logic [HASH_W-1:0]   mac_q, mac_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [NUM_KEYS-1:0] kvalid_q, kvalid_d;
  logic [WORD_W-1:0]   key_q [NUM_KEYS][16];
  logic [WORD_W-1:0]   key_d [NUM_KEYS][16];

  logic slot_ok;
  logic kslot_ok;
  logic abort_hit;

  assign slot_ok   = ({1'b0, slot_sel_i} < NK) && kvalid_q[slot_sel_i];
  assign kslot_ok  = ({1'b0, key_slot_i} < NK);
  assign abort_hit = abort_i && (state_q != IDLE);

  assign sha_start_o = first_q;
  assign busy_o      = (state_q != IDLE);
  assign mac_o       = mac_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    first_d     = 1'b0;
    slot_d      = slot_q;
    inner_d     = inner_q;
    mac_d       = mac_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    kvalid_d    = kvalid_q;
    key_d       = key_q;
    sha_valid_o = 1'b0;
    sha_data_o  = '0;
    sha_last_o  = 1'b0;
    msg_ready_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i && slot_ok) begin
          state_d = IN_KEY;
          cnt_d   = '0;
          first_d = 1'b1;
          slot_d  = slot_sel_i;
        end else if (start_i) begin
          err_d = 1'b1;
        end
        // a write racing an accepted start loses
        if (key_wr_i && kslot_ok && !(start_i && slot_ok)) begin
          key_d[key_slot_i][key_idx_i] = key_word_i;
          if (key_idx_i == 4'hf) kvalid_d[key_slot_i] = 1'b1;
        end
      end
      IN_KEY: begin
        sha_valid_o = 1'b1;
        sha_data_o  = key_q[slot_q][cnt_q] ^ IPAD;
        if (sha_ready_i) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'hf) state_d = IN_MSG;
        end
      end
      IN_MSG: begin
        sha_valid_o = msg_valid_i;
        sha_data_o  = msg_data_i;
        sha_last_o  = msg_last_i;
        msg_ready_o = sha_ready_i;
        if (msg_valid_i && sha_ready_i && msg_last_i) state_d = IN_WAIT;
      end
      IN_WAIT: begin
        if (sha_done_i) begin
          inner_d = sha_hash_i;
          state_d = OUT_KEY;
          first_d = 1'b1;
          cnt_d   = '0;
        end
      end
      OUT_KEY: begin
        sha_valid_o = 1'b1;
        sha_data_o  = key_q[slot_q][cnt_q] ^ OPAD;
        if (sha_ready_i) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'hf) state_d = OUT_DIG;
        end
      end
      OUT_DIG: begin
        sha_valid_o = 1'b1;
        sha_data_o  = inner_q[HASH_W - WORD_W*(int'(cnt_q)+1) +: WORD_W];
        sha_last_o  = (cnt_q == LAST_DIG);
        if (sha_ready_i) begin
          if (cnt_q == LAST_DIG) begin
            cnt_d   = '0;
            state_d = OUT_WAIT;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      OUT_WAIT: begin
        if (sha_done_i) begin
          mac_d   = sha_hash_i;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // abort beats a same-cycle digest
    if (abort_hit) begin
      state_d = IDLE;
      cnt_d   = '0;
      first_d = 1'b0;
      inner_d = '0;
      mac_d   = mac_q;
      done_d  = 1'b0;
    end

`ifdef HMAC_KEY_ZEROIZE_EN
    if (done_d || abort_hit) begin
      for (int i = 0; i < 16; i++) key_d[slot_q][i] = '0;
      kvalid_d[slot_q] = 1'b0;
    end
`else
    // keys persist until overwritten or reset
`endif
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      slot_q   <= '0;
      inner_q  <= '0;
      mac_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      kvalid_q <= '0;
      key_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      slot_q   <= slot_d;
      inner_q  <= inner_d;
      mac_q    <= mac_d;
      done_q   <= done_d;
      err_q    <= err_d;
      kvalid_q <= kvalid_d;
      key_q    <= key_d;
    end
  end

endmodule

// File: tb/tb_lw_hmac_multikey.sv
// tb_lw_hmac_multikey: RFC 4231 TC2 through a behavioural SHA-256 core.
// Scoreboard of expected done/err events checked by an independent monitor.
module tb_lw_hmac_multikey;

  logic         clk_i = 0;
  logic         aresetn_i = 0;
  logic         key_wr_i = 0;
  logic [1:0]   key_slot_i = 0;
  logic [3:0]   key_idx_i = 0;
  logic [31:0]  key_word_i = 0;
  logic         start_i = 0;
  logic [1:0]   slot_sel_i = 0;
  logic         abort_i = 0;
  logic         msg_valid_i = 0;
  logic [31:0]  msg_data_i = 0;
  logic         msg_last_i = 0;
  logic         msg_ready_o;
  logic         sha_start_o;
  logic         sha_valid_o;
  logic [31:0]  sha_data_o;
  logic         sha_last_o;
  logic         sha_ready_i = 0;
  logic         sha_done_i = 0;
  logic [255:0] sha_hash_i = 0;
  logic [255:0] mac_o;
  logic         done_o;
  logic         busy_o;
  logic         err_o;

  lw_hmac_multikey dut (
    .clk_i(clk_i), .aresetn_i(aresetn_i),
    .key_wr_i(key_wr_i), .key_slot_i(key_slot_i),
    .key_idx_i(key_idx_i), .key_word_i(key_word_i),
    .start_i(start_i), .slot_sel_i(slot_sel_i), .abort_i(abort_i),
    .msg_valid_i(msg_valid_i), .msg_data_i(msg_data_i),
    .msg_last_i(msg_last_i), .msg_ready_o(msg_ready_o),
    .sha_start_o(sha_start_o), .sha_valid_o(sha_valid_o),
    .sha_data_o(sha_data_o), .sha_last_o(sha_last_o),
    .sha_ready_i(sha_ready_i), .sha_done_i(sha_done_i),
    .sha_hash_i(sha_hash_i), .mac_o(mac_o), .done_o(done_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef HMAC_KEY_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  localparam logic [255:0] TC2_MAC =
    256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843;
  localparam logic [31:0] MSG [7] = '{
    32'h77686174, 32'h20646f20, 32'h79612077, 32'h616e7420,
    32'h666f7220, 32'h6e6f7468, 32'h696e673f};
  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef struct packed {
    logic         is_err;
    logic [255:0] mac;
  } ev_t;

  ev_t         exp_q[$];
  int          len_q[$];
  logic [31:0] cbuf[$];
  int          checks = 0;
  int          errors = 0;
  int          pass_no = 0;
  int          n_starts = 0;
  int          done_cd = 0;
  bit          stall_en = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256(input logic [31:0] msg[$]);
    logic [31:0] m[$];
    logic [31:0] w[64];
    logic [31:0] hv[8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    logic [63:0] nbits;
    m = msg;
    nbits = 64'(msg.size()) * 64'd32;
    m.push_back(32'h8000_0000);
    while (m.size() % 16 != 14) m.push_back(32'h0);
    m.push_back(nbits[63:32]);
    m.push_back(nbits[31:0]);
    hv = H0;
    for (int blk = 0; blk < m.size() / 16; blk++) begin
      for (int t = 0; t < 64; t++) begin
        if (t < 16) w[t] = m[blk*16 + t];
        else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10))
                  + w[t-7]
                  + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
                  + w[t-16];
      end
      a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
      e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
      for (int t = 0; t < 64; t++) begin
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
           + ((e & f) ^ (~e & g)) + K[t] + w[t];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
           + ((a & b) ^ (a & c) ^ (b & c));
        h = g; g = f; f = e; e = d + t1;
        d = c; c = b; b = a; a = t1 + t2;
      end
      hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
      hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
    end
    return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
  endfunction

  // behavioural SHA core: inputs change on negedge, transfers observed at +1
  always @(negedge clk_i) begin
    sha_done_i = 1'b0;
    if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) begin
        sha_hash_i = sha256(cbuf);
        sha_done_i = 1'b1;
      end
    end
    sha_ready_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (!aresetn_i) prev_stall = 1'b0;
    if (prev_stall)
      chk("stall_hold", {sha_valid_o, sha_data_o}, {1'b1, prev_data});
    if (sha_start_o) begin
      cbuf.delete();
      pass_no++;
      n_starts++;
    end
    prev_stall = sha_valid_o && !sha_ready_i;
    prev_data  = sha_data_o;
    if (sha_valid_o && sha_ready_i) begin
      cbuf.push_back(sha_data_o);
      if (sha_last_o) begin
        done_cd = 3;
        if (len_q.size() == 0) chk("pass_unexpected", cbuf.size(), 0);
        else chk("pass_len", cbuf.size(), len_q.pop_front());
      end
    end
  end

  always @(negedge clk_i) begin
    #1;
    if (done_o || err_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_evt", {done_o, err_o}, 2'b00);
      end else begin
        ev_t ev;
        ev = exp_q.pop_front();
        chk("evt_kind", {done_o, err_o}, {!ev.is_err, ev.is_err});
        if (!ev.is_err) chk("mac", mac_o, ev.mac);
      end
    end
  end

  task automatic load_key(input logic [1:0] s, input logic [31:0] w0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      key_wr_i   = 1'b1;
      key_slot_i = s;
      key_idx_i  = 4'(i);
      key_word_i = (i == 0) ? w0 : 32'h0;
    end
    @(negedge clk_i);
    key_wr_i = 1'b0;
  endtask

  task automatic issue_start(input logic [1:0] s);
    @(negedge clk_i);
    start_i    = 1'b1;
    slot_sel_i = s;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic send_msg(input int n, input bit stall);
    int i = 0;
    int g = 0;
    bit acc = 0;
    while (i < n && g < 2000) begin
      @(negedge clk_i);
      g++;
      if (acc) msg_valid_i = 1'b0;
      acc = 1'b0;
      if (!msg_valid_i) begin
        msg_valid_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        msg_data_i  = MSG[i];
        msg_last_i  = (i == 6);
      end
      #1;
      if (msg_valid_i && msg_ready_o) begin
        acc = 1'b1;
        i++;
      end
    end
    @(negedge clk_i);
    msg_valid_i = 1'b0;
    msg_last_i  = 1'b0;
    chk("msg_sent", i, n);
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || busy_o) && t < 3000) begin
      @(negedge clk_i);
      #2;
      t++;
    end
    chk("evt_pending", exp_q.size(), 0);
  endtask

  task automatic run_tc2(input bit stall);
    if (ZEROIZE) load_key(2'd1, 32'h4a656665);
    exp_q.push_back('{1'b0, TC2_MAC});
    len_q.push_back(23);
    len_q.push_back(24);
    stall_en = stall;
    issue_start(2'd1);
    send_msg(7, stall);
    wait_done();
    stall_en = 1'b0;
  endtask

  initial begin
    int s0;
    int t;
    bit quiet;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_ctl", {busy_o, done_o, err_o, sha_start_o, sha_valid_o,
                    sha_last_o, msg_ready_o}, 7'b0);
    chk("rst_mac", mac_o, 256'h0);
    @(negedge clk_i);
    aresetn_i = 1'b1;

    load_key(2'd1, 32'h4a656665);

    exp_q.push_back('{1'b1, 256'h0});
    s0 = n_starts;
    issue_start(2'd2);
    quiet = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      #1;
      quiet |= busy_o | sha_start_o | sha_valid_o;
    end
    chk("err_quiet", quiet, 1'b0);
    chk("err_nostart", n_starts, s0);
    wait_done();

    run_tc2(1'b0);
`ifdef HMAC_KEY_ZEROIZE_EN
    s0 = n_starts;
    exp_q.push_back('{1'b1, 256'h0});
    issue_start(2'd1);
    wait_done();
    chk("zero_nostart", n_starts, s0);
`endif
    run_tc2(1'b0);
    run_tc2(1'b0);

    // stalled run with a key write that must be dropped while busy
    fork
      run_tc2(1'b1);
      begin
        repeat (30) @(negedge clk_i);
        key_wr_i   = 1'b1;
        key_slot_i = 2'd1;
        key_idx_i  = 4'd0;
        key_word_i = 32'hffff_ffff;
        @(negedge clk_i);
        key_wr_i = 1'b0;
      end
    join

    if (ZEROIZE) load_key(2'd1, 32'h4a656665);
    len_q.push_back(23);
    s0 = pass_no;
    issue_start(2'd1);
    send_msg(7, 1'b0);
    t = 0;
    while (!(pass_no == s0 + 2 && cbuf.size() == 20) && t < 500) begin
      @(negedge clk_i);
      #2;
      t++;
    end
    chk("abort_reach", cbuf.size(), 20);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    #1;
    chk("abort_idle", {busy_o, sha_valid_o}, 2'b00);
    repeat (10) @(negedge clk_i);
    chk("abort_mac", mac_o, TC2_MAC);

    run_tc2(1'b0);

    s0 = pass_no;
    issue_start(2'd1);
    send_msg(3, 1'b0);
    @(negedge clk_i);
    aresetn_i = 1'b0;
    #1;
    chk("rst_mid_ctl", {busy_o, done_o, err_o, sha_start_o, sha_valid_o,
                        sha_last_o, msg_ready_o}, 7'b0);
    chk("rst_mid_mac", mac_o, 256'h0);
    repeat (2) @(negedge clk_i);
    aresetn_i = 1'b1;
    exp_q.push_back('{1'b1, 256'h0});
    s0 = n_starts;
    issue_start(2'd1);
    wait_done();
    chk("rst_nostart", n_starts, s0);

    repeat (5) @(negedge clk_i);
    chk("len_left", len_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/lw_hmac_multikey.md
Name: lw_hmac_multikey

Overview:
- Parametrised HMAC sequencer that drives an external lw SHA core through a streaming word interface.
- Holds NUM_KEYS pre-loaded key slots, so one key serves many messages without re-streaming it.
- Runs inner pass (K^ipad block, then message), then outer pass (K^opad block, then inner digest), and returns the MAC.
- Sits between the bus-side message/key source and the SHA core. The core does all length padding when sha_last_o is set on the final word.

Parameters:
- WORD_W, 32, word width in bits; 32 or 64 only. Byte pads are replicated to WORD_W.
- DIGEST_WORDS, 8, number of words of the inner digest fed to the outer pass and presented on mac_o.
- NUM_KEYS, 4, number of key slots, ≥1. SLOT_W = max(1, $clog2(NUM_KEYS)).

Ports:
- clk_i  in  1  clock
- aresetn_i  in  1  asynchronous active-low reset
- key_wr_i  in  1  key word write strobe
- key_slot_i  in  SLOT_W  slot being written
- key_idx_i  in  4  word index within the 16-word key block
- key_word_i  in  WORD_W  key word, raw (unpadded)
- start_i  in  1  start an HMAC using slot slot_sel_i
- slot_sel_i  in  SLOT_W  key slot for this operation
- abort_i  in  1  abandon the current operation
- msg_valid_i  in  1  message word valid
- msg_data_i  in  WORD_W  message word
- msg_last_i  in  1  final message word
- msg_ready_o  out  1  message word accepted when high together with msg_valid_i
- sha_start_o  out  1  one-cycle start pulse to the SHA core
- sha_valid_o  out  1  word valid to the core
- sha_data_o  out  WORD_W  word to the core
- sha_last_o  out  1  final word of the current pass
- sha_ready_i  in  1  core accepts a word
- sha_done_i  in  1  core digest valid (one-cycle pulse)
- sha_hash_i  in  DIGEST_WORDS*WORD_W  core digest; word 0 in the MS position
- mac_o  out  DIGEST_WORDS*WORD_W  final MAC
- done_o  out  1  one-cycle pulse when mac_o is updated
- busy_o  out  1  operation in progress
- err_o  out  1  one-cycle pulse: start rejected (slot not loaded)

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - Key store zeroed; all slot-valid bits cleared; word counter 0.
  - Reset mid-operation aborts immediately and produces no done_o.
- Key load:
  - Accepted only when busy_o=0; a key_wr_i during busy is dropped.
  - Write stores key_word_i at [key_slot_i][key_idx_i].
  - Writing idx 15 sets that slot's valid bit.
  - Shorter keys: the host writes the remaining words as zero.
- Transfers: a word moves to the core only on sha_valid_o && sha_ready_i. sha_data_o is held stable while sha_valid_o=1 and sha_ready_i=0.
- States:
  - IDLE:
    - start_i with the slot valid → IN_KEY; busy_o=1 from the next cycle; counter=0.
    - start_i with the slot invalid → err_o pulse next cycle, remain IDLE.
  - IN_KEY:
    - sha_start_o=1 on the first cycle of the state only.
    - Sends key[counter]^{0x36..}, counter 0→15, sha_last_o=0.
    - After word 15 transfers → IN_MSG.
  - IN_MSG: combinational pass-through.
    - sha_valid_o=msg_valid_i, msg_ready_o=sha_ready_i, sha_data_o=msg_data_i, sha_last_o=msg_last_i.
    - Last word transferred → IN_WAIT.
    - Messages are ≥1 word.
    - msg_ready_o=0 in every other state.
  - IN_WAIT: on sha_done_i, latch sha_hash_i into the inner register → OUT_KEY.
  - OUT_KEY: sha_start_o pulse on the first cycle; sends key^{0x5c..} words 0..15 → OUT_DIG.
  - OUT_DIG:
    - Sends inner words 0..DIGEST_WORDS-1.
    - sha_last_o=1 on the final word → OUT_WAIT.
  - OUT_WAIT: on sha_done_i, mac_o←sha_hash_i and done_o=1 for one cycle → IDLE.
- mac_o holds its value until the next done_o.
- Abort:
  - abort_i in any non-IDLE state → IDLE next cycle.
  - No done_o; mac_o unchanged; the inner register is cleared.
  - Abort has priority over a same-cycle sha_done_i.
  - abort_i in IDLE has no effect.
- start_i while busy is ignored.
- key_wr_i in the same cycle as an accepted start_i is dropped.
- Counter is 4 bits and wraps 15→0 at the IN_KEY/OUT_KEY exit.

Optional Feature:
- Macro HMAC_KEY_ZEROIZE_EN.
- When defined:
  - On done_o or an accepted abort, the used slot's 16 words are cleared to 0 and its valid bit is cleared in the same cycle.
  - A subsequent start_i on that slot gives err_o.
- When undefined: keys persist until overwritten or reset.

Test Plan:
- WORD_W=32, RFC 4231 TC2 loaded in slot 1:
  - Key "Jefe" (0x4a656665, rest 0); message "what do ya want for nothing?" as 7 words, last on word 7.
  - → done_o once; mac_o=5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843.
- Same slot, same message three times back-to-back without reloading the key → identical MAC each time.
- Zeroize variant → second start gives err_o and no sha_start_o.
- start_i on never-written slot 2 → err_o one pulse; busy_o, sha_start_o and sha_valid_o stay 0.
- Random sha_ready_i/msg_valid_i stalls (~50%) during the TC2 run → same MAC.
  - Exactly 16+7 inner and 16+8 outer transfers.
  - sha_data_o stable during every stall.
- abort_i during OUT_DIG word 3 → IDLE next cycle, no done_o, mac_o keeps its previous value.
  - A fresh TC2 run afterwards gives the correct MAC.
- aresetn_i low during IN_MSG → all outputs 0, all slots invalid; the next start on slot 1 gives err_o.
